// File: rtl/seg_scan_if.sv
// Host-side bundle for seg_scan_ctrl: frame data and scan controls in, one digit's drive out.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_mask;
  logic [3:0]            dig_val;
  logic [DIGITS-1:0]     dig_sel;
  logic                  dp_out;
  logic                  frame_done;

  modport master (
    output en, load, din, dp_in, blank_mask,
    input  dig_val, dig_sel, dp_out, frame_done
  );

  modport slave (
    input  en, load, din, dp_in, blank_mask,
    output dig_val, dig_sel, dp_out, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: dead-time blank then show per digit slot,
// double-buffered frame data committed only when the scan (re)starts at digit 0.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  seg_scan_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  typedef logic [DIGITS-1:0][3:0] frame_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              commit, wrap;

  frame_t            din_frame;
  frame_t            act_q, act_d;
  frame_t            pend_q, pend_d;
  logic [DIGITS-1:0] adp_q, adp_d;
  logic [DIGITS-1:0] pdp_q, pdp_d;
  logic              pend_vld_q, pend_vld_d;

  logic [3:0]        dig_val_q, dig_val_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic              dp_out_q, dp_out_d;
  logic              frame_done_q;

  assign din_frame = bus.din;

  // Slot sequencing; commit marks every entry into BLANK of digit 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    commit  = 1'b0;
    wrap    = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          commit  = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              commit = 1'b1;
              wrap   = 1'b1;
            end else begin
              idx_d  = idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A load coinciding with a commit goes straight to the active frame.
  always_comb begin
    act_d      = act_q;
    adp_d      = adp_q;
    pend_d     = pend_q;
    pdp_d      = pdp_q;
    pend_vld_d = pend_vld_q;
    if (commit && bus.load) begin
      act_d      = din_frame;
      adp_d      = bus.dp_in;
      pend_vld_d = 1'b0;
    end else if (commit && pend_vld_q) begin
      act_d      = pend_q;
      adp_d      = pdp_q;
      pend_vld_d = 1'b0;
    end else if (bus.load) begin
      pend_d     = din_frame;
      pdp_d      = bus.dp_in;
      pend_vld_d = 1'b1;
    end
  end

  // Outputs follow the next state so they register in step with it.
  always_comb begin
    dig_val_d = '0;
    dig_sel_d = '0;
    dp_out_d  = 1'b0;
    if (state_d != IDLE) begin
      dig_val_d = act_d[idx_d];
    end
    if (state_d == SHOW && !bus.blank_mask[idx_d]) begin
      dig_sel_d = DIGITS'(1) << idx_d;
      dp_out_d  = adp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      act_q        <= '0;
      adp_q        <= '0;
      pend_q       <= '0;
      pdp_q        <= '0;
      pend_vld_q   <= 1'b0;
      dig_val_q    <= '0;
      dig_sel_q    <= '0;
      dp_out_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      act_q        <= act_d;
      adp_q        <= adp_d;
      pend_q       <= pend_d;
      pdp_q        <= pdp_d;
      pend_vld_q   <= pend_vld_d;
      dig_val_q    <= dig_val_d;
      dig_sel_q    <= dig_sel_d;
      dp_out_q     <= dp_out_d;
      frame_done_q <= wrap;
    end
  end

  assign bus.dig_val    = dig_val_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.dp_out     = dp_out_q;
  assign bus.frame_done = frame_done_q;

endmodule
